// File: rtl/ser_rx_link_ctrl.sv
// Receive link controller: classifies 16-bit words, tracks comma lock and
// error density, and requests aligner re-acquisition when the link is lost.
module ser_rx_link_ctrl #(
    parameter int unsigned LOCK_COMMAS = 4,
    parameter int unsigned ERR_LIMIT   = 3,
    parameter int unsigned GOOD_RUN    = 16,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic        ser_rx_clk_i,
    input  logic        ser_rx_rst_i,
    input  logic [15:0] ser_r_i,
    input  logic        ser_rklsb_i,
    input  logic        ser_rkmsb_i,
    input  logic        clr_err_i,
    output logic        link_up_o,
    output logic        realign_o,
    output logic [15:0] data_o,
    output logic        data_valid_o,
    output logic [15:0] err_count_o,
    output logic [1:0]  state_o
);

    localparam int unsigned CW = (LOCK_COMMAS > 0) ? $clog2(LOCK_COMMAS + 1) : 1;
    localparam int unsigned HW = (ERR_LIMIT > 0) ? $clog2(ERR_LIMIT + 1) : 1;
    localparam int unsigned GW = (GOOD_RUN > 0) ? $clog2(GOOD_RUN + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] CommaLast  = CW'(LOCK_COMMAS - 1);
    localparam logic [HW-1:0] HitsLast   = HW'(ERR_LIMIT - 1);
    localparam logic [GW-1:0] GoodLast   = GW'(GOOD_RUN - 1);
    localparam logic [TW-1:0] TimeoutMax = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        StLos   = 2'd0,
        StAcq   = 2'd1,
        StSync  = 2'd2,
        StCheck = 2'd3
    } state_e;

    state_e        state_q;
    logic [CW-1:0] comma_cnt_q;
    logic [HW-1:0] err_hits_q;
    logic [GW-1:0] good_cnt_q;
    logic [TW-1:0] timeout_q;
    logic          realign_q;
    logic [15:0]   data_q;
    logic          data_valid_q;
    logic [15:0]   err_count_q;

    logic is_comma;
    logic is_data;
    logic is_err;
    logic locked;

    assign is_comma = ({ser_rkmsb_i, ser_rklsb_i} == 2'b11) && (ser_r_i == 16'h3C3C);
    assign is_data  = ({ser_rkmsb_i, ser_rklsb_i} == 2'b00);
    assign is_err   = ~is_comma & ~is_data;
    assign locked   = (state_q == StSync) || (state_q == StCheck);

    always_ff @(posedge ser_rx_clk_i or posedge ser_rx_rst_i) begin
        if (ser_rx_rst_i) begin
            state_q      <= StLos;
            comma_cnt_q  <= '0;
            err_hits_q   <= '0;
            good_cnt_q   <= '0;
            timeout_q    <= '0;
            realign_q    <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            data_q       <= ser_r_i;
            data_valid_q <= is_data && locked;
            realign_q    <= 1'b0;

            // Clear has priority over a coincident error word.
            if (clr_err_i) begin
                err_count_q <= '0;
            end else if (is_err && (state_q != StLos) && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end

            case (state_q)
                StLos: begin
                    if (is_comma) begin
                        timeout_q <= '0;
                        if (LOCK_COMMAS <= 1) begin
                            state_q     <= StSync;
                            comma_cnt_q <= '0;
                        end else begin
                            state_q     <= StAcq;
                            comma_cnt_q <= CW'(1);
                        end
                    end else if (timeout_q == TimeoutMax) begin
                        timeout_q <= '0;
                        realign_q <= 1'b1;
                    end else begin
                        timeout_q <= timeout_q + TW'(1);
                    end
                end
                StAcq: begin
                    if (is_comma) begin
                        if (comma_cnt_q == CommaLast) begin
                            state_q     <= StSync;
                            comma_cnt_q <= '0;
                        end else begin
                            comma_cnt_q <= comma_cnt_q + CW'(1);
                        end
                    end else if (is_err) begin
                        state_q     <= StLos;
                        comma_cnt_q <= '0;
                        timeout_q   <= '0;
                    end
                end
                StSync: begin
                    if (is_err) begin
                        good_cnt_q <= '0;
                        if (ERR_LIMIT <= 1) begin
                            state_q    <= StLos;
                            err_hits_q <= '0;
                            timeout_q  <= '0;
                            realign_q  <= 1'b1;
                        end else begin
                            state_q    <= StCheck;
                            err_hits_q <= HW'(1);
                        end
                    end
                end
                StCheck: begin
                    if (is_err) begin
                        good_cnt_q <= '0;
                        if (err_hits_q == HitsLast) begin
                            state_q    <= StLos;
                            err_hits_q <= '0;
                            timeout_q  <= '0;
                            realign_q  <= 1'b1;
                        end else begin
                            err_hits_q <= err_hits_q + HW'(1);
                        end
                    end else if (good_cnt_q == GoodLast) begin
                        // A full clean run retires one outstanding hit.
                        good_cnt_q <= '0;
                        err_hits_q <= err_hits_q - HW'(1);
                        if (err_hits_q == HW'(1)) begin
                            state_q <= StSync;
                        end
                    end else begin
                        good_cnt_q <= good_cnt_q + GW'(1);
                    end
                end
                default: state_q <= StLos;
            endcase
        end
    end

    assign link_up_o    = (state_q == StSync) || (state_q == StCheck);
    assign realign_o    = realign_q;
    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign err_count_o  = err_count_q;
    assign state_o      = state_q;

    realign_single_a: assert property (
        @(posedge ser_rx_clk_i) disable iff (ser_rx_rst_i) realign_q |=> !realign_q
    );

    err_sat_a: assert property (
        @(posedge ser_rx_clk_i) disable iff (ser_rx_rst_i)
        (err_count_q == 16'hFFFF && !clr_err_i) |=> (err_count_q == 16'hFFFF)
    );

endmodule

// File: tb/tb_ser_rx_link_ctrl.sv
// Scoreboarded bench for ser_rx_link_ctrl: lock, error, timeout, clear,
// saturation and asynchronous reset behaviour.
module tb_ser_rx_link_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] r   = '0;
    logic        kl  = 1'b0;
    logic        km  = 1'b0;
    logic        clr = 1'b0;

    logic        link_up, realign, data_valid;
    logic [15:0] data, err_count;
    logic [1:0]  state;

    logic        s_link_up, s_realign, s_data_valid;
    logic [15:0] s_data, s_err_count;
    logic [1:0]  s_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    ser_rx_link_ctrl u_dut (
        .ser_rx_clk_i (clk),
        .ser_rx_rst_i (rst),
        .ser_r_i      (r),
        .ser_rklsb_i  (kl),
        .ser_rkmsb_i  (km),
        .clr_err_i    (clr),
        .link_up_o    (link_up),
        .realign_o    (realign),
        .data_o       (data),
        .data_valid_o (data_valid),
        .err_count_o  (err_count),
        .state_o      (state)
    );

    // Large error limit so CHECK absorbs enough errors to saturate the counter.
    ser_rx_link_ctrl #(
        .ERR_LIMIT (100000)
    ) u_sat (
        .ser_rx_clk_i (clk),
        .ser_rx_rst_i (rst),
        .ser_r_i      (r),
        .ser_rklsb_i  (kl),
        .ser_rkmsb_i  (km),
        .clr_err_i    (clr),
        .link_up_o    (s_link_up),
        .realign_o    (s_realign),
        .data_o       (s_data),
        .data_valid_o (s_data_valid),
        .err_count_o  (s_err_count),
        .state_o      (s_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [15:0] w, input logic vld);
        logic [16:0] e;
        exp_q.push_back({vld, w});
        {km, kl} = k;
        r = w;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("data_o", {16'd0, data}, {16'd0, e[15:0]});
        check_eq("data_valid_o", {31'd0, data_valid}, {31'd0, e[16]});
    endtask

    task automatic comma();
        send(2'b11, 16'h3C3C, 1'b0);
    endtask

    task automatic err_word();
        send(2'b01, 16'h00BC, 1'b0);
    endtask

    task automatic dat(input logic [15:0] w, input logic vld);
        send(2'b00, w, vld);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"},   {30'd0, state},      32'd0);
        check_eq({tag, "_link"},    {31'd0, link_up},    32'd0);
        check_eq({tag, "_realign"}, {31'd0, realign},    32'd0);
        check_eq({tag, "_data"},    {16'd0, data},       32'd0);
        check_eq({tag, "_valid"},   {31'd0, data_valid}, 32'd0);
        check_eq({tag, "_err"},     {16'd0, err_count},  32'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // LOS timeout: realign every 1024 non-comma words.
        for (int i = 1; i <= 2048; i++) begin
            dat(16'(i), 1'b0);
            check_eq("timeout_realign", {31'd0, realign}, {31'd0, (i % 1024) == 0});
        end
        check_eq("timeout_state", {30'd0, state}, 32'd0);

        // Acquire lock.
        comma();
        check_eq("acq_w1", {30'd0, state}, 32'd1);
        comma();
        comma();
        check_eq("acq_w3", {30'd0, state}, 32'd1);
        check_eq("acq_link", {31'd0, link_up}, 32'd0);
        comma();
        check_eq("sync_w4", {30'd0, state}, 32'd2);
        check_eq("sync_link", {31'd0, link_up}, 32'd1);

        // One error then a clean run of 16 returns to SYNC.
        err_word();
        check_eq("check_enter", {30'd0, state}, 32'd3);
        check_eq("check_err1", {16'd0, err_count}, 32'd1);
        for (int i = 1; i <= 16; i++) begin
            dat(16'h1000 + 16'(i), 1'b1);
            if (i == 15) check_eq("check_hold15", {30'd0, state}, 32'd3);
        end
        check_eq("check_exit16", {30'd0, state}, 32'd2);
        check_eq("check_errcnt", {16'd0, err_count}, 32'd1);

        // Three errors within the good-run window drop lock.
        clr = 1'b1;
        dat(16'hA5A5, 1'b1);
        clr = 1'b0;
        check_eq("clr_err", {16'd0, err_count}, 32'd0);
        err_word();
        dat(16'h1111, 1'b1);
        dat(16'h2222, 1'b1);
        err_word();
        check_eq("drop_hits2", {30'd0, state}, 32'd3);
        dat(16'h3333, 1'b1);
        dat(16'h4444, 1'b1);
        err_word();
        check_eq("drop_state", {30'd0, state}, 32'd0);
        check_eq("drop_link", {31'd0, link_up}, 32'd0);
        check_eq("drop_realign", {31'd0, realign}, 32'd1);
        check_eq("drop_errcnt", {16'd0, err_count}, 32'd3);
        dat(16'h5A5A, 1'b0);
        check_eq("drop_realign_off", {31'd0, realign}, 32'd0);

        // Error during ACQ: back to LOS without realign.
        clr = 1'b1;
        dat(16'h0001, 1'b0);
        clr = 1'b0;
        comma();
        comma();
        check_eq("acq2_state", {30'd0, state}, 32'd1);
        dat(16'h5555, 1'b0);
        check_eq("acq_hold_data", {30'd0, state}, 32'd1);
        err_word();
        check_eq("acq_err_state", {30'd0, state}, 32'd0);
        check_eq("acq_err_norealign", {31'd0, realign}, 32'd0);
        check_eq("acq_err_cnt", {16'd0, err_count}, 32'd1);
        dat(16'h0002, 1'b0);
        check_eq("acq_err_norealign2", {31'd0, realign}, 32'd0);

        // Clear coincident with a counted error wins.
        repeat (4) comma();
        check_eq("relock", {30'd0, state}, 32'd2);
        clr = 1'b1;
        err_word();
        clr = 1'b0;
        check_eq("clr_wins_state", {30'd0, state}, 32'd3);
        check_eq("clr_wins_cnt", {16'd0, err_count}, 32'd0);
        repeat (16) dat(16'h7777, 1'b1);
        err_word();
        for (int i = 0; i < 16; i++) dat(16'hBEEF, 1'b1);
        check_eq("presync_state", {30'd0, state}, 32'd2);
        check_eq("presync_err", {16'd0, err_count}, 32'd1);
        check_eq("presync_data", {16'd0, data}, 32'h0000BEEF);

        // Asynchronous reset mid-SYNC, no clock edge.
        rst = 1'b1;
        #2;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First word after reset is classified normally.
        comma();
        check_eq("post_rst_acq", {30'd0, state}, 32'd1);
        repeat (3) comma();
        check_eq("sat_sync", {30'd0, s_state}, 32'd2);

        // Saturation on the high error-limit instance.
        for (int i = 1; i <= 65536; i++) begin
            err_word();
            if (i == 65534) check_eq("sat_fffe", {16'd0, s_err_count}, 32'h0000FFFE);
        end
        check_eq("sat_ffff", {16'd0, s_err_count}, 32'h0000FFFF);
        check_eq("sat_state", {30'd0, s_state}, 32'd3);
        check_eq("sat_main_err", {16'd0, err_count}, 32'd3);
        check_eq("sat_main_state", {30'd0, state}, 32'd0);
        err_word();
        check_eq("sat_hold", {16'd0, s_err_count}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
